// File: rtl/seg7_pkg.sv
// Shared 7-segment codes (active-low, bit 6 = segment g) and the countdown FSM state encoding.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'd64;
  localparam logic [6:0] SEG_1     = 7'd121;
  localparam logic [6:0] SEG_2     = 7'd36;
  localparam logic [6:0] SEG_3     = 7'd48;
  localparam logic [6:0] SEG_4     = 7'd25;
  localparam logic [6:0] SEG_5     = 7'd18;
  localparam logic [6:0] SEG_6     = 7'd2;
  localparam logic [6:0] SEG_7     = 7'd120;
  localparam logic [6:0] SEG_8     = 7'd0;
  localparam logic [6:0] SEG_9     = 7'd16;
  localparam logic [6:0] SEG_BLANK = 7'd127;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Switch inputs can present 10..15; anything above 9 saturates to 9.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control inputs and display/status outputs of the countdown timer, grouped as one bundle.
interface countdown_timer_if;
  logic       load;
  logic       start;
  logic       pause;
  logic [3:0] preset_tens;
  logic [3:0] preset_units;
  logic [6:0] units_HEX;
  logic [6:0] tens_HEX;
  logic [6:0] HEX2;
  logic [6:0] HEX3;
  logic [6:0] HEX4;
  logic [6:0] HEX5;
  logic       running;
  logic       ending;
  logic       done_pulse;

  modport master (
    output load, start, pause, preset_tens, preset_units,
    input  units_HEX, tens_HEX, HEX2, HEX3, HEX4, HEX5, running, ending, done_pulse
  );

  modport slave (
    input  load, start, pause, preset_tens, preset_units,
    output units_HEX, tens_HEX, HEX2, HEX3, HEX4, HEX5, running, ending, done_pulse
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment code; non-BCD values show "0".
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_0;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_0;
    endcase
  end

endmodule

// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer (99..00) stepping once per TICK_DIV clocks.
// Define COUNTDOWN_BLINK_EN to blink "00" at half the tick period while in DONE.
module countdown_timer
  import seg7_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int DIV_W    = 26
) (
  input logic              clk,
  input logic              clr_n,
  countdown_timer_if.slave bus
);

  state_t           state, state_nxt;
  logic [3:0]       tens, units, tens_nxt, units_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [3:0]       pre_tens, pre_units;
  logic [6:0]       tens_seg, units_seg;
  logic [6:0]       tens_hex, units_hex;
  logic             running_r, ending_r, pulse_r;
  logic             blank_nxt;

  assign pre_tens  = clamp_bcd(bus.preset_tens);
  assign pre_units = clamp_bcd(bus.preset_units);

  always_comb begin
    state_nxt = state;
    tens_nxt  = tens;
    units_nxt = units;
    div_nxt   = div_cnt;
    case (state)
      IDLE: begin
        if (bus.load) begin
          tens_nxt  = pre_tens;
          units_nxt = pre_units;
        end else if (bus.start) begin
          if (tens != 4'd0 || units != 4'd0) begin
            state_nxt = RUN;
            div_nxt   = '0;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      RUN: begin
        if (bus.load) begin
          tens_nxt  = pre_tens;
          units_nxt = pre_units;
          div_nxt   = '0;
          state_nxt = IDLE;
        end else if (bus.pause) begin
          state_nxt = PAUSED;
        end else if (div_cnt == DIV_W'(TICK_DIV - 1)) begin
          // RUN is only ever entered with a non-zero count, so tens > 0 when units wraps.
          div_nxt = '0;
          if (units == 4'd0) begin
            units_nxt = 4'd9;
            tens_nxt  = tens - 4'd1;
          end else begin
            units_nxt = units - 4'd1;
          end
          if (tens_nxt == 4'd0 && units_nxt == 4'd0) state_nxt = DONE;
        end else begin
          div_nxt = div_cnt + DIV_W'(1);
        end
      end
      PAUSED: begin
        if (bus.load) begin
          tens_nxt  = pre_tens;
          units_nxt = pre_units;
          state_nxt = IDLE;
        end else if (!bus.pause) begin
          state_nxt = RUN;
        end
      end
      DONE: begin
        if (bus.load) begin
          tens_nxt  = pre_tens;
          units_nxt = pre_units;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef COUNTDOWN_BLINK_EN
  localparam int HALF_DIV = (TICK_DIV / 2 > 0) ? TICK_DIV / 2 : 1;

  logic [DIV_W-1:0] blink_cnt, blink_cnt_nxt;
  logic             blink_off, blink_off_nxt;

  // Phase restarts on DONE entry so the display always begins with "00" visible.
  always_comb begin
    blink_cnt_nxt = blink_cnt;
    blink_off_nxt = blink_off;
    if (state_nxt == DONE && state != DONE) begin
      blink_cnt_nxt = '0;
      blink_off_nxt = 1'b0;
    end else if (state == DONE) begin
      if (blink_cnt == DIV_W'(HALF_DIV - 1)) begin
        blink_cnt_nxt = '0;
        blink_off_nxt = ~blink_off;
      end else begin
        blink_cnt_nxt = blink_cnt + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt_nxt;
      blink_off <= blink_off_nxt;
    end
  end

  assign blank_nxt = (state_nxt == DONE) && blink_off_nxt;
`else
  assign blank_nxt = 1'b0;
`endif

  // Decoding the next count lets the display register update on the same edge as the count.
  seg7_decode u_units_dec (.digit(units_nxt), .seg(units_seg));
  seg7_decode u_tens_dec  (.digit(tens_nxt),  .seg(tens_seg));

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state     <= IDLE;
      tens      <= 4'd0;
      units     <= 4'd0;
      div_cnt   <= '0;
      tens_hex  <= SEG_0;
      units_hex <= SEG_0;
      running_r <= 1'b0;
      ending_r  <= 1'b0;
      pulse_r   <= 1'b0;
    end else begin
      state     <= state_nxt;
      tens      <= tens_nxt;
      units     <= units_nxt;
      div_cnt   <= div_nxt;
      tens_hex  <= blank_nxt ? SEG_BLANK : tens_seg;
      units_hex <= blank_nxt ? SEG_BLANK : units_seg;
      running_r <= (state_nxt == RUN);
      ending_r  <= (state_nxt == DONE);
      pulse_r   <= (state_nxt == DONE) && (state != DONE);
    end
  end

  assign bus.units_HEX  = units_hex;
  assign bus.tens_HEX   = tens_hex;
  assign bus.HEX2       = SEG_BLANK;
  assign bus.HEX3       = SEG_BLANK;
  assign bus.HEX4       = SEG_BLANK;
  assign bus.HEX5       = SEG_BLANK;
  assign bus.running    = running_r;
  assign bus.ending     = ending_r;
  assign bus.done_pulse = pulse_r;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus randomized traffic against an integer-count model.
module tb_countdown_timer;
  localparam int TICK_DIV = 4;
  localparam int DIV_W    = 4;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;

  countdown_timer_if bus();

  countdown_timer #(.TICK_DIV(TICK_DIV), .DIV_W(DIV_W)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int seg_tab [10] = '{64, 121, 36, 48, 25, 18, 2, 120, 0, 16};

  typedef enum {M_IDLE, M_RUN, M_PAUSED, M_DONE} mode_e;
  mode_e m_mode    = M_IDLE;
  int    m_count   = 0;
  int    m_elapsed = 0;
  int    m_age     = 0;
  bit    m_pulse   = 1'b0;

  // Model: count is a plain integer, elapsed counts active RUN cycles since the last step.
  task automatic model_step();
    int pt, pu, pre;
    m_pulse = 1'b0;
    pt  = (bus.preset_tens  > 4'd9) ? 9 : int'(bus.preset_tens);
    pu  = (bus.preset_units > 4'd9) ? 9 : int'(bus.preset_units);
    pre = pt * 10 + pu;
    if (!clr_n) begin
      m_mode = M_IDLE; m_count = 0; m_elapsed = 0; m_age = 0;
      return;
    end
    case (m_mode)
      M_IDLE: begin
        if (bus.load) m_count = pre;
        else if (bus.start) begin
          if (m_count > 0) begin m_mode = M_RUN; m_elapsed = 0; end
          else begin m_mode = M_DONE; m_pulse = 1'b1; m_age = 0; end
        end
      end
      M_RUN: begin
        if (bus.load) begin m_count = pre; m_mode = M_IDLE; end
        else if (bus.pause) m_mode = M_PAUSED;
        else begin
          m_elapsed++;
          if (m_elapsed == TICK_DIV) begin
            m_elapsed = 0;
            m_count--;
            if (m_count == 0) begin m_mode = M_DONE; m_pulse = 1'b1; m_age = 0; end
          end
        end
      end
      M_PAUSED: begin
        if (bus.load) begin m_count = pre; m_mode = M_IDLE; end
        else if (!bus.pause) m_mode = M_RUN;
      end
      M_DONE: begin
        if (bus.load) begin m_count = pre; m_mode = M_IDLE; end
        else m_age++;
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  function automatic int exp_hex(input bit tens_digit);
    int d;
    d = tens_digit ? (m_count / 10) : (m_count % 10);
`ifdef COUNTDOWN_BLINK_EN
    if (m_mode == M_DONE && ((m_age / (TICK_DIV / 2)) % 2) == 1) return 127;
`endif
    return seg_tab[d];
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_preset(input int t, input int u);
    bus.preset_tens  = 4'(t);
    bus.preset_units = 4'(u);
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    tick(); tick();
    clr_n = 1'b1;
    n_checks++; if (bus.tens_HEX !== 7'd64) begin n_errors++; $display("FAIL rst_tens: got %0d expected 64", bus.tens_HEX); end
    n_checks++; if (bus.units_HEX !== 7'd64) begin n_errors++; $display("FAIL rst_units: got %0d expected 64", bus.units_HEX); end
    n_checks++; if ({bus.HEX2, bus.HEX3, bus.HEX4, bus.HEX5} !== {4{7'd127}}) begin n_errors++; $display("FAIL rst_blank: got %0d %0d %0d %0d expected 127 each", bus.HEX2, bus.HEX3, bus.HEX4, bus.HEX5); end
    n_checks++; if ({bus.running, bus.ending, bus.done_pulse} !== 3'b000) begin n_errors++; $display("FAIL rst_flags: got %b expected 000", {bus.running, bus.ending, bus.done_pulse}); end
  endtask

  task automatic test_countdown();
    bus.load = 1'b1; set_preset(1, 2);
    tick();
    bus.load = 1'b0;
    n_checks++; if ({bus.tens_HEX, bus.units_HEX} !== {7'd121, 7'd36}) begin n_errors++; $display("FAIL cd_load: got %0d/%0d expected 121/36", bus.tens_HEX, bus.units_HEX); end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_checks++; if (bus.running !== 1'b1) begin n_errors++; $display("FAIL cd_running: got %b expected 1", bus.running); end
    for (int v = 11; v >= 0; v--) begin
      for (int c = 0; c < TICK_DIV; c++) begin
        int shown;
        tick();
        shown = (c == TICK_DIV - 1) ? v : v + 1;
        n_checks++;
        if ({bus.tens_HEX, bus.units_HEX} !== {7'(seg_tab[shown / 10]), 7'(seg_tab[shown % 10])}) begin
          n_errors++;
          $display("FAIL cd_step v=%0d c=%0d: got %0d/%0d expected %0d/%0d", v, c, bus.tens_HEX, bus.units_HEX, seg_tab[shown / 10], seg_tab[shown % 10]);
        end
      end
    end
    n_checks++; if ({bus.running, bus.ending, bus.done_pulse} !== 3'b011) begin n_errors++; $display("FAIL cd_done: got %b expected 011", {bus.running, bus.ending, bus.done_pulse}); end
    tick();
    n_checks++; if ({bus.ending, bus.done_pulse} !== 2'b10) begin n_errors++; $display("FAIL cd_pulse_once: got %b expected 10", {bus.ending, bus.done_pulse}); end
  endtask

  task automatic test_pause();
    bus.load = 1'b1; set_preset(0, 5);
    tick();
    bus.load = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    n_checks++; if (bus.units_HEX !== 7'd25) begin n_errors++; $display("FAIL pause_pre: got %0d expected 25", bus.units_HEX); end
    bus.pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if ({bus.running, bus.tens_HEX, bus.units_HEX} !== {1'b0, 7'd64, 7'd25}) begin
        n_errors++;
        $display("FAIL pause_hold i=%0d: got run=%b %0d/%0d expected run=0 64/25", i, bus.running, bus.tens_HEX, bus.units_HEX);
      end
    end
    bus.pause = 1'b0;
    tick();
    n_checks++; if ({bus.running, bus.units_HEX} !== {1'b1, 7'd25}) begin n_errors++; $display("FAIL pause_resume: got run=%b %0d expected run=1 25", bus.running, bus.units_HEX); end
    tick();
    n_checks++; if (bus.units_HEX !== 7'd25) begin n_errors++; $display("FAIL pause_resume1: got %0d expected 25", bus.units_HEX); end
    tick();
    n_checks++; if (bus.units_HEX !== 7'd48) begin n_errors++; $display("FAIL pause_resume2: got %0d expected 48", bus.units_HEX); end
  endtask

  task automatic test_clamp_zero();
    bus.load = 1'b1; set_preset(15, 15);
    tick();
    n_checks++; if ({bus.tens_HEX, bus.units_HEX, bus.running} !== {7'd16, 7'd16, 1'b0}) begin n_errors++; $display("FAIL clamp: got %0d/%0d run=%b expected 16/16 run=0", bus.tens_HEX, bus.units_HEX, bus.running); end
    set_preset(0, 0);
    tick();
    bus.load = 1'b0;
    n_checks++; if ({bus.tens_HEX, bus.units_HEX} !== {7'd64, 7'd64}) begin n_errors++; $display("FAIL zero_load: got %0d/%0d expected 64/64", bus.tens_HEX, bus.units_HEX); end
    bus.start = 1'b1;
    tick();
    n_checks++; if ({bus.running, bus.ending, bus.done_pulse} !== 3'b011) begin n_errors++; $display("FAIL zero_start: got %b expected 011", {bus.running, bus.ending, bus.done_pulse}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if ({bus.running, bus.ending, bus.done_pulse} !== 3'b010) begin n_errors++; $display("FAIL zero_stay i=%0d: got %b expected 010", i, {bus.running, bus.ending, bus.done_pulse}); end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_priority_reset();
    bus.load = 1'b1; set_preset(3, 0);
    tick();
    bus.load = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if ({bus.tens_HEX, bus.units_HEX} !== {7'd36, 7'd16}) begin n_errors++; $display("FAIL prio_run: got %0d/%0d expected 36/16", bus.tens_HEX, bus.units_HEX); end
    bus.load = 1'b1; bus.start = 1'b1; set_preset(4, 7);
    tick();
    n_checks++; if ({bus.running, bus.tens_HEX, bus.units_HEX} !== {1'b0, 7'd25, 7'd120}) begin n_errors++; $display("FAIL prio_load: got run=%b %0d/%0d expected run=0 25/120", bus.running, bus.tens_HEX, bus.units_HEX); end
    bus.load = 1'b0;
    tick();
    bus.start = 1'b0;
    n_checks++; if (bus.running !== 1'b1) begin n_errors++; $display("FAIL prio_restart: got %b expected 1", bus.running); end
    for (int i = 0; i < 6; i++) tick();
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
    n_checks++; if ({bus.running, bus.ending, bus.tens_HEX, bus.units_HEX} !== {2'b00, 7'd64, 7'd64}) begin n_errors++; $display("FAIL midrun_rst: got run=%b end=%b %0d/%0d expected 0 0 64/64", bus.running, bus.ending, bus.tens_HEX, bus.units_HEX); end
    tick();
    n_checks++; if ({bus.running, bus.units_HEX} !== {1'b0, 7'd64}) begin n_errors++; $display("FAIL post_rst: got run=%b %0d expected run=0 64", bus.running, bus.units_HEX); end
  endtask

  task automatic test_done_display();
    bus.load = 1'b1; set_preset(0, 1);
    tick();
    bus.load = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < TICK_DIV; i++) tick();
    n_checks++; if ({bus.ending, bus.tens_HEX, bus.units_HEX} !== {1'b1, 7'd64, 7'd64}) begin n_errors++; $display("FAIL done_entry: got end=%b %0d/%0d expected 1 64/64", bus.ending, bus.tens_HEX, bus.units_HEX); end
    for (int i = 1; i <= 8; i++) begin
      int want;
      tick();
`ifdef COUNTDOWN_BLINK_EN
      want = (((i / (TICK_DIV / 2)) % 2) == 1) ? 127 : 64;
`else
      want = 64;
`endif
      n_checks++;
      if ({bus.tens_HEX, bus.units_HEX} !== {7'(want), 7'(want)}) begin
        n_errors++;
        $display("FAIL done_disp i=%0d: got %0d/%0d expected %0d/%0d", i, bus.tens_HEX, bus.units_HEX, want, want);
      end
    end
    bus.load = 1'b1; set_preset(3, 4);
    tick();
    bus.load = 1'b0;
    n_checks++; if ({bus.ending, bus.tens_HEX, bus.units_HEX} !== {1'b0, 7'd48, 7'd25}) begin n_errors++; $display("FAIL done_exit: got end=%b %0d/%0d expected 0 48/25", bus.ending, bus.tens_HEX, bus.units_HEX); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      clr_n     = ($urandom_range(0, 149) != 0);
      bus.load  = ($urandom_range(0, 24) == 0);
      bus.start = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) bus.pause = ~bus.pause;
      set_preset(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      tick();
      n_checks++;
      if (bus.tens_HEX !== 7'(exp_hex(1'b1)) || bus.units_HEX !== 7'(exp_hex(1'b0))) begin
        n_errors++;
        $display("FAIL rnd_hex i=%0d: got %0d/%0d expected %0d/%0d (count %0d)", i, bus.tens_HEX, bus.units_HEX, exp_hex(1'b1), exp_hex(1'b0), m_count);
      end
      n_checks++;
      if ({bus.running, bus.ending, bus.done_pulse} !== {m_mode == M_RUN, m_mode == M_DONE, m_pulse}) begin
        n_errors++;
        $display("FAIL rnd_flags i=%0d: got %b expected %b", i, {bus.running, bus.ending, bus.done_pulse}, {m_mode == M_RUN, m_mode == M_DONE, m_pulse});
      end
      n_checks++;
      if ({bus.HEX2, bus.HEX3, bus.HEX4, bus.HEX5} !== {4{7'd127}}) begin
        n_errors++;
        $display("FAIL rnd_blank i=%0d: got %0d %0d %0d %0d expected 127 each", i, bus.HEX2, bus.HEX3, bus.HEX4, bus.HEX5);
      end
    end
    clr_n = 1'b1; bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
  endtask

  initial begin
    bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
    set_preset(0, 0);
    test_reset();
    test_countdown();
    test_pause();
    test_clamp_zero();
    test_priority_reset();
    test_done_display();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
